branch_resolve_unit: RTL
========================

# branch_resolve_unit

Parametrised, clocked branch resolution for the superscalar execute stage. Each cycle it accepts up to `LANES` in-order ops, evaluates compares and branches against an internal flag register with in-bundle flag forwarding, and picks the oldest taken branch. It then issues one registered redirect to fetch, holding it until fetch acknowledges, and reports which younger lanes to squash.

## Interface
- `ADDR_W`, 16: PC / branch target width.
- `DATA_W`, 16: compare operand width.
- `LANES`, 2: ops per bundle, lane 0 oldest; legal range 1..4.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: bundle present.
- `in_ready` out 1: bundle accepted when `in_valid && in_ready`.
- `lane_valid` in `LANES`: per-lane op valid.
- `lane_op` in `3*LANES`: op code per lane, encoded in `bru_pkg`.
- `lane_pc` in `ADDR_W*LANES`: PC of each op.
- `lane_target` in `ADDR_W*LANES`: branch target.
- `lane_a`, `lane_b` in `DATA_W*LANES` each: compare operands.
- `lane_pred_taken` in `LANES`: fetch prediction; used only when `BRU_PREDICT_EN` is defined.
- `flush` in 1: pipeline flush from a later stage.
- `redirect_valid` out 1: redirect pending.
- `redirect_pc` out `ADDR_W`: fetch restart address.
- `redirect_ack` in 1: fetch consumed the redirect.
- `squash_mask` out `LANES`: lanes younger than the resolving branch in the redirecting bundle.
- `flags` out 2: architectural flags; bit0 E, bit1 GT.
- `taken_cnt` out 16: count of taken branches, wraps at 0xFFFF→0.

## Operation
- Op codes:
  - `OP_NOP` = 0.
  - `OP_CMP` = 1: E = (a == b); GT = signed a > b.
  - `OP_B` = 2: unconditional.
  - `OP_BEQ` = 3: taken if E.
  - `OP_BGT` = 4: taken if GT.
  - Codes 5–7 are treated as NOP.
- Lane walk, from lane 0 upward:
  - The running flag copy starts from the `flags` register.
  - Each valid `OP_CMP` updates the running copy, so a compare in lane i is visible to a branch in lane j > i within the same bundle.
- Resolving lane = the lowest lane that requires a redirect.
  - Lanes above it are squashed: they contribute nothing to the flags or to `taken_cnt`.
- On an accepted bundle, the following register at the clock edge:
  - `flags` ← running copy after the last non-squashed lane.
  - `taken_cnt` += number of taken, non-squashed branches; at most 1 per bundle, since the first taken branch squashes all younger lanes.
  - If there is a resolving lane: `redirect_valid` ← 1, `redirect_pc` ← its address, `squash_mask` ← bits above the resolving lane.
- `in_ready = !redirect_valid || redirect_ack`, combinational; a bundle may be accepted in the same cycle as the ack.
- `redirect_ack` with no new redirect: `redirect_valid` ← 0, `squash_mask` ← 0; `redirect_pc` holds its value.
- `flush`:
  - Clears `redirect_valid` and `squash_mask` next edge and discards any bundle presented that cycle.
  - `flags` and `taken_cnt` are unaffected.
  - Flush has priority over accept.
- `lane_valid = 0` lanes are NOPs. An empty bundle is accepted and changes nothing.

## Timing
- Resolution latency is 1 cycle: bundle accepted at edge N → `redirect_valid` visible after edge N.
- `redirect_valid`, `redirect_pc`, `squash_mask`, `flags`, and `taken_cnt` are all registered.
- Reset, asynchronous: `redirect_valid` 0, `redirect_pc` 0, `squash_mask` 0, `flags` 0, `taken_cnt` 0; `in_ready` is then 1.
- A reset asserted mid-redirect drops the redirect immediately.
- Redirect held without ack: `redirect_pc` and `squash_mask` stay stable and `in_ready` stays 0.
- Ack and a new redirecting bundle in the same cycle: the new redirect loads and `redirect_valid` stays 1.

## Configuration
- `BRU_PREDICT_EN` undefined:
  - Every taken branch redirects to `lane_target`.
  - Not-taken branches never redirect.
  - `lane_pred_taken` is ignored.
- `BRU_PREDICT_EN` defined: a branch redirects only on a misprediction.
  - Taken and predicted not-taken → redirect to `lane_target`.
  - Not taken and predicted taken → redirect to `lane_pc + 1`, modulo 2^ADDR_W.
  - A correctly predicted taken branch still squashes younger lanes and counts in `taken_cnt`, but raises no redirect.

## Structure
- `bru_pkg` holds:
  - the op code constants and the 3-bit op typedef;
  - the flag bit indices `FLAG_E` and `FLAG_GT`.
- Sub-module `branch_lane_eval`, combinational, one instance per lane:
  - inputs: op, operands, incoming flags, target, pc, prediction;
  - outputs: outgoing flags, taken, redirect request, redirect address.
- The top level chains the lane instances and holds all registers and the handshake.

## Test plan
- Reset, then bundle lane0 `OP_B` target 0x0040 → `redirect_valid` = 1, `redirect_pc` = 0x0040, `squash_mask` = 2'b10, `taken_cnt` = 1.
- Lane0 CMP a=5, b=5; lane1 BEQ target 0x0100 → forwarded E=1; redirect to 0x0100; `flags` = 2'b01.
- Lane0 BGT taken (flags = 2'b10); lane1 CMP a=1, b=2 → lane1 squashed; `flags` remain 2'b10.
- Redirect held 3 cycles without ack → `in_ready` = 0 and outputs stable; ack plus new B to 0x0200 in the same cycle → `redirect_pc` = 0x0200.
- `flush` together with `in_valid` carrying a taken branch → no redirect; `taken_cnt` unchanged.
- With `BRU_PREDICT_EN`: BEQ at pc 0x00FF, E=0, predicted taken → `redirect_pc` = 0x0100; correctly predicted taken B → no redirect, `taken_cnt` increments.

Source files
------------

// File: rtl/bru_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bru_pkg
// Description : Shared definitions for the branch resolution unit.
//               Holds the 3-bit op code type, the op code constants and the
//               bit positions of the architectural flags.
//               Optional feature macro used by the unit: BRU_PREDICT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package bru_pkg;

   typedef logic [2:0] op_t;

   localparam op_t OP_NOP = 3'd0;
   localparam op_t OP_CMP = 3'd1;
   localparam op_t OP_B   = 3'd2;
   localparam op_t OP_BEQ = 3'd3;
   localparam op_t OP_BGT = 3'd4;
   // Codes 5..7 are reserved and decode as NOP.

   localparam int FLAG_E  = 0;
   localparam int FLAG_GT = 1;

endpackage : bru_pkg
`default_nettype wire

// File: rtl/branch_lane_eval.sv
`default_nettype none
// ============================================================================
// Module      : branch_lane_eval
// Description : Combinational evaluation of a single lane. Applies a compare
//               to the incoming flags or decides whether a branch is taken
//               and whether it needs a fetch redirect.
//               Config macro: BRU_PREDICT_EN (redirect only on mispredict).
// Revision    : 1.0 - initial release
// Ports       : op_i           lane op (already gated to NOP if lane invalid)
//               a_i, b_i       compare operands
//               flags_i        flags seen by this lane
//               target_i, pc_i branch target and op PC
//               pred_taken_i   fetch prediction
//               flags_o        flags after this lane
//               taken_o        branch is taken
//               redir_o        lane requests a redirect
//               redir_addr_o   redirect address
// ============================================================================
module branch_lane_eval
   import bru_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic [2:0]        op_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic [1:0]        flags_i,
   input  logic [ADDR_W-1:0] target_i,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic              pred_taken_i,
   output logic [1:0]        flags_o,
   output logic              taken_o,
   output logic              redir_o,
   output logic [ADDR_W-1:0] redir_addr_o
);

   logic w_is_branch;

   always_comb begin
      flags_o     = flags_i;
      taken_o     = 1'b0;
      w_is_branch = 1'b0;
      case (op_i)
         OP_CMP: begin
            flags_o[FLAG_E]  = (a_i == b_i);
            flags_o[FLAG_GT] = ($signed(a_i) > $signed(b_i));
         end
         OP_B: begin
            w_is_branch = 1'b1;
            taken_o     = 1'b1;
         end
         OP_BEQ: begin
            w_is_branch = 1'b1;
            taken_o     = flags_i[FLAG_E];
         end
         OP_BGT: begin
            w_is_branch = 1'b1;
            taken_o     = flags_i[FLAG_GT];
         end
         default: ;
      endcase
   end

`ifdef BRU_PREDICT_EN
   // Redirect only when the outcome disagrees with fetch's prediction; a
   // wrongly predicted-taken branch restarts at the fall-through PC.
   assign redir_o      = w_is_branch && (taken_o != pred_taken_i);
   assign redir_addr_o = taken_o ? target_i : (pc_i + {{(ADDR_W-1){1'b0}}, 1'b1});
`else
   logic w_unused_pred;
   assign w_unused_pred = ^{pred_taken_i, pc_i, w_is_branch};
   assign redir_o       = taken_o;
   assign redir_addr_o  = target_i;
`endif

endmodule : branch_lane_eval
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit
// Description : Execute-stage branch resolution for a bundle of LANES ops.
//               Chains per-lane evaluators with in-bundle flag forwarding,
//               picks the oldest lane that stops the bundle, and holds a
//               registered redirect until fetch acknowledges it.
//               Config macro: BRU_PREDICT_EN (redirect on mispredict only).
// Revision    : 1.0 - initial release
// Ports       : clk, rst_n        clock, async active-low reset
//               in_valid/in_ready bundle handshake
//               lane_*            per-lane op fields (lane 0 oldest)
//               flush             drop pending redirect and current bundle
//               redirect_*        redirect to fetch with ack
//               squash_mask       younger lanes killed by the redirect
//               flags, taken_cnt  architectural flags and taken counter
// ============================================================================
module branch_resolve_unit
   import bru_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter int LANES  = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [LANES-1:0]         lane_valid,
   input  logic [3*LANES-1:0]       lane_op,
   input  logic [ADDR_W*LANES-1:0]  lane_pc,
   input  logic [ADDR_W*LANES-1:0]  lane_target,
   input  logic [DATA_W*LANES-1:0]  lane_a,
   input  logic [DATA_W*LANES-1:0]  lane_b,
   input  logic [LANES-1:0]         lane_pred_taken,
   input  logic                     flush,
   output logic                     redirect_valid,
   output logic [ADDR_W-1:0]        redirect_pc,
   input  logic                     redirect_ack,
   output logic [LANES-1:0]         squash_mask,
   output logic [1:0]               flags,
   output logic [15:0]              taken_cnt
);

   logic              redirect_valid_q, redirect_valid_d;
   logic [ADDR_W-1:0] redirect_pc_q,    redirect_pc_d;
   logic [LANES-1:0]  squash_mask_q,    squash_mask_d;
   logic [1:0]        flags_q,          flags_d;
   logic [15:0]       taken_cnt_q,      taken_cnt_d;

   // chain_flags[i] is what lane i sees; chain_flags[i+1] is after lane i.
   logic [1:0]        chain_flags [LANES+1];
   logic [LANES-1:0]  lane_taken;
   logic [LANES-1:0]  lane_redir;
   logic [ADDR_W-1:0] lane_addr   [LANES];

   assign chain_flags[0] = flags_q;

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      op_t w_op;
      assign w_op = lane_valid[gi] ? lane_op[3*gi +: 3] : OP_NOP;

      branch_lane_eval #(
         .ADDR_W (ADDR_W),
         .DATA_W (DATA_W)
      ) u_eval (
         .op_i         (w_op),
         .a_i          (lane_a[DATA_W*gi +: DATA_W]),
         .b_i          (lane_b[DATA_W*gi +: DATA_W]),
         .flags_i      (chain_flags[gi]),
         .target_i     (lane_target[ADDR_W*gi +: ADDR_W]),
         .pc_i         (lane_pc[ADDR_W*gi +: ADDR_W]),
         .pred_taken_i (lane_pred_taken[gi]),
         .flags_o      (chain_flags[gi+1]),
         .taken_o      (lane_taken[gi]),
         .redir_o      (lane_redir[gi]),
         .redir_addr_o (lane_addr[gi])
      );
   end

   // Walk the lanes oldest-first. The first lane that is taken or redirects
   // ends the bundle: everything younger is ignored for flags and counting.
   // With prediction enabled a correctly predicted taken branch stops the
   // walk without raising a redirect.
   logic              w_stopped;
   logic              w_taken_any;
   logic              w_any_redir;
   logic [1:0]        w_new_flags;
   logic [ADDR_W-1:0] w_redir_pc;
   logic [LANES-1:0]  w_redir_mask;

   always_comb begin
      w_stopped    = 1'b0;
      w_taken_any  = 1'b0;
      w_any_redir  = 1'b0;
      w_new_flags  = flags_q;
      w_redir_pc   = redirect_pc_q;
      w_redir_mask = '0;
      for (int i = 0; i < LANES; i++) begin
         if (!w_stopped) begin
            w_new_flags = chain_flags[i+1];
            if (lane_taken[i] || lane_redir[i]) begin
               w_stopped   = 1'b1;
               w_taken_any = lane_taken[i];
               w_any_redir = lane_redir[i];
               w_redir_pc  = lane_addr[i];
               for (int j = 0; j < LANES; j++) begin
                  w_redir_mask[j] = (j > i);
               end
            end
         end
      end
   end

   logic w_accept;
   assign in_ready = !redirect_valid_q || redirect_ack;
   assign w_accept = in_valid && in_ready;

   always_comb begin
      redirect_valid_d = redirect_valid_q;
      redirect_pc_d    = redirect_pc_q;
      squash_mask_d    = squash_mask_q;
      flags_d          = flags_q;
      taken_cnt_d      = taken_cnt_q;
      if (flush) begin
         // Flush wins over accept; the presented bundle is dropped.
         redirect_valid_d = 1'b0;
         squash_mask_d    = '0;
      end else if (w_accept) begin
         flags_d     = w_new_flags;
         taken_cnt_d = taken_cnt_q + {15'd0, w_taken_any};
         if (w_any_redir) begin
            redirect_valid_d = 1'b1;
            redirect_pc_d    = w_redir_pc;
            squash_mask_d    = w_redir_mask;
         end else begin
            // Accept implies no redirect pending or it is being acked.
            redirect_valid_d = 1'b0;
            squash_mask_d    = '0;
         end
      end else if (redirect_ack) begin
         redirect_valid_d = 1'b0;
         squash_mask_d    = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         squash_mask_q    <= '0;
         flags_q          <= 2'b00;
         taken_cnt_q      <= 16'd0;
      end else begin
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
         squash_mask_q    <= squash_mask_d;
         flags_q          <= flags_d;
         taken_cnt_q      <= taken_cnt_d;
      end
   end

   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;
   assign squash_mask    = squash_mask_q;
   assign flags          = flags_q;
   assign taken_cnt      = taken_cnt_q;

endmodule : branch_resolve_unit
`default_nettype wire
